// File: rtl/imem_wb_fetch.sv
// imem_wb_fetch: Wishbone B4 pipelined single-outstanding read master for instruction fetch.
// Flushed requests are drained silently; misaligned PCs and timeouts return an error response.
module imem_wb_fetch #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_flush_i,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_rvalid_o,
    output logic        fetch_err_o,
    output logic        fetch_busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_adr, r_rdata, w_rdata;
    logic          r_rvalid, r_err, w_rvalid, w_err, w_latch, w_resp, w_tmo;
    logic [CW-1:0] r_cnt;

    assign w_resp = wbm_ack_i | wbm_err_i;
    assign w_tmo  = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        w_next   = r_state;
        w_rvalid = 1'b0;
        w_err    = 1'b0;
        w_latch  = 1'b0;
        w_rdata  = r_rdata;
        case (r_state)
            IDLE: if (fetch_req_i && !fetch_flush_i) begin
                if (fetch_addr_i[1:0] == 2'b00) begin
                    w_latch = 1'b1;
                    w_next  = REQ;
                end else if (!r_rvalid) begin
                    // gated on r_rvalid so a held misaligned request cannot pulse back-to-back
                    w_rvalid = 1'b1;
                    w_err    = 1'b1;
                    w_rdata  = '0;
                end
            end
            REQ: if (fetch_flush_i) begin
                w_next = (wbm_stall_i || w_resp) ? IDLE : DRAIN;
            end else if (!wbm_stall_i) begin
                w_next   = w_resp ? IDLE : WAIT;
                w_rvalid = w_resp;
                w_err    = wbm_err_i;
                w_rdata  = (wbm_ack_i && !wbm_err_i) ? wbm_dat_i : r_rdata;
            end
            WAIT: if (w_resp) begin
                w_next   = IDLE;
                w_rvalid = !fetch_flush_i;
                w_err    = wbm_err_i && !fetch_flush_i;
                w_rdata  = (fetch_flush_i || wbm_err_i) ? r_rdata : wbm_dat_i;
            end else if (fetch_flush_i) begin
                w_next = DRAIN;
            end else if (w_tmo) begin
                w_next   = IDLE;
                w_rvalid = 1'b1;
                w_err    = 1'b1;
            end
            DRAIN: if (w_resp || w_tmo) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_adr    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_adr    <= w_latch ? fetch_addr_i : r_adr;
            r_rdata  <= w_rdata;
            r_rvalid <= w_rvalid;
            r_err    <= w_err;
            r_cnt    <= ((r_state == WAIT || r_state == DRAIN) && w_next == r_state) ? r_cnt + 1'b1 : '0;
        end
    end

    assign fetch_rdata_o  = r_rdata;
    assign fetch_rvalid_o = r_rvalid;
    assign fetch_err_o    = r_err;
    assign fetch_busy_o   = (r_state != IDLE) && (w_next != IDLE);
    assign wbm_cyc_o      = r_state != IDLE;
    assign wbm_stb_o      = r_state == REQ;
    assign wbm_we_o       = 1'b0;
    assign wbm_sel_o      = 4'hF;
    assign wbm_adr_o      = r_adr;
endmodule
